mm_iddmm_ctrl: RTL and testbench
================================

# mm_iddmm_ctrl

Parametrised sequencer for the iddmm Montgomery multiplier core (`mmp_iddmm_sp`). It replaces hard-wired modulus and ρ constants with a runtime-loadable key store. It accepts a K·N-bit operand pair over a valid/ready stream and issues one, or a chain of, Montgomery passes in one of four modes. It streams the N-word result out with backpressure. It sits between the Paillier/RSA exponentiation control and the core; the core's write/task ports are exposed as `core_*`.

## Interface
Parameters:
- `K`, 128, bits per word
- `N`, 32, words per operand (low word first everywhere)
- `ADDR_W`, `$clog2(N)`, word-address width

Ports:
- `clk` in 1: clock
- `rst_n` in 1: asynchronous, active-low reset
- `key_wr` in 1: key word write strobe, honoured in IDLE only, ignored otherwise
- `key_sel` in 2: 0 = m[addr], 1 = ρ[addr] (2^(2KN) mod m), 2 = m1, 3 = commit
- `key_addr` in ADDR_W: word index for m/ρ
- `key_data` in K: key word
- `key_valid` out 1: set by commit, cleared by reset or by any m/ρ/m1 write
- `op_start` in 1: start request, sampled in IDLE
- `op_mode` in 2: 0 MONT (x·y·R⁻¹), 1 TO_MONT (x·ρ·R⁻¹), 2 FROM_MONT (x·1·R⁻¹), 3 MODMUL (x·y mod m)
- `in_x`, `in_y` in K: operand words; `in_y` is ignored in modes 1 and 2
- `in_valid` in 1, `in_ready` out 1: operand beat handshake
- `out_data` out K, `out_valid` out 1, `out_last` out 1, `out_ready` in 1: result stream
- `busy` out 1: high from accepted start until the last result beat
- `op_err` out 1: one-cycle error pulse
- `core_wr_ena` out 3, `core_wr_addr` out ADDR_W, `core_wr_x`/`core_wr_y`/`core_wr_m`/`core_wr_m1` out K: core write ports
- `core_task_req` out 1, `core_task_end` in 1, `core_task_grant` in 1, `core_task_res` in K: core task handshake

## Operation
- States: IDLE → LOAD → FEED → WAIT → (FEED for the next pass | OUT) → IDLE.
- IDLE, `op_start` sampled:
  - If `key_valid` = 0, or mode 3 is not compiled in: pulse `op_err`, stay in IDLE.
  - Otherwise latch the mode and go to LOAD.
- LOAD:
  - `in_ready` = 1.
  - N accepted beats fill the x and y buffers at index = beat count.
  - Go to FEED after beat N-1.
- FEED: N cycles. Each cycle drives `core_wr_ena` = 3'b111 and `core_wr_addr` = i (0..N-1). Operands per pass:
  - `core_wr_m` = m[i].
  - `core_wr_x`/`core_wr_y` = the pass operands below.
  - The "one" operand is word0 = 1, all other words 0.
  - `core_wr_m1` = m1 constantly.
- Passes:
  - MONT: (x, y).
  - TO_MONT: (x, ρ).
  - FROM_MONT: (x, one).
  - MODMUL: A (x, ρ) → r1; B (y, ρ) → r2; C (r1, r2) → r3; D (r3, one) → result.
- WAIT:
  - `core_task_req` = 1 until the cycle `core_task_end` is seen.
  - Each `core_task_grant` writes `core_task_res` to the pass destination at the grant count, then increments the count.
  - On `core_task_end`:
    - If grant count ≠ N: pulse `op_err`, drop the result, go to IDLE.
    - Else if more passes remain: go to FEED with the count cleared.
    - Else: go to OUT.
- OUT:
  - Presents result word j.
  - `out_last` is high on j = N-1.
  - j advances on `out_valid && out_ready`; go to IDLE after the last beat.
- Result buffer is reused as scratch. MODMUL adds r1/r2 buffers; r3 overwrites r1.

## Timing
- Reset values:
  - All outputs 0; `key_valid` 0; state IDLE.
  - Buffers and key store are not reset.
- A start accepted at edge t gives `in_ready` = 1 from t+1.
- With `in_valid` held high:
  - FEED occupies t+N+1 … t+2N.
  - `core_task_req` rises at t+2N+1.
  - `core_task_req` falls the cycle after `core_task_end`.
- Back-to-back passes: the next FEED starts the cycle after `core_task_end`.
- First `out_valid` comes the cycle after the final `core_task_end`.
- Output is registered. While `out_ready` is low, `out_data`/`out_last` hold stable.
- `core_wr_ena` is 0 outside FEED.
- `op_start` outside IDLE is ignored, with no error.
- A key write coinciding with an accepted `op_start` is ignored.
- Reset mid-operation: all outputs go to 0 immediately, including `core_task_req`.

## Configuration
- `MM_IDDMM_CTRL_MODMUL_EN` defined:
  - Mode 3 is implemented, along with the r1/r2 buffers and pass counter.
- Undefined:
  - Mode 3 start → `op_err` pulse, no core activity.
  - Modes 0–2 are unchanged.

## Test plan
- K=16, N=4, no commit; `op_start` mode 0 → `op_err` one cycle, `core_wr_ena` stays 0, `busy` 0.
- Key committed, mode 2, x = {1,2,3,4} → `core_wr_y` = 0x0001, 0, 0, 0 at addr 0..3. With a core model granting {5,6,7,8}: `out_data` = 5, 6, 7, 8 and `out_last` on 8.
- Mode 0 result streamed with `out_ready` low for 3 cycles on beat 1 → word held stable, 4 beats total, no loss or duplicate.
- Mode 3 with the macro, golden core model, m = 0xF1 (word0), x = 3, y = 5 → 4 task_req windows, result 15; without the macro → `op_err`.
- Core model issues 3 grants before `core_task_end` → `op_err` pulse, no `out_valid`, back to IDLE.
- `rst_n` low during WAIT → `core_task_req`, `busy`, `key_valid` are 0 immediately; a fresh key load and op then complete normally.

Source files
------------

// File: rtl/mm_iddmm_ctrl.sv
// Sequencer for the iddmm Montgomery core: key store, operand load, pass feed/wait, result stream.
// Define MM_IDDMM_CTRL_MODMUL_EN to build mode 3 (4-pass x*y mod m with r1/r2 scratch buffers).
module mm_iddmm_ctrl #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr,
  input  logic [1:0]        key_sel,
  input  logic [ADDR_W-1:0] key_addr,
  input  logic [K-1:0]      key_data,
  output logic              key_valid,
  input  logic              op_start,
  input  logic [1:0]        op_mode,
  input  logic [K-1:0]      in_x,
  input  logic [K-1:0]      in_y,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [K-1:0]      out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              op_err,
  output logic [2:0]        core_wr_ena,
  output logic [ADDR_W-1:0] core_wr_addr,
  output logic [K-1:0]      core_wr_x,
  output logic [K-1:0]      core_wr_y,
  output logic [K-1:0]      core_wr_m,
  output logic [K-1:0]      core_wr_m1,
  output logic              core_task_req,
  input  logic              core_task_end,
  input  logic              core_task_grant,
  input  logic [K-1:0]      core_task_res
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_WAIT, S_OUT} state_t;

  localparam logic [ADDR_W:0] C_LAST = (ADDR_W+1)'(N-1);
  localparam logic [ADDR_W:0] C_N    = (ADDR_W+1)'(N);

  state_t            r_state, w_next;
  logic [ADDR_W:0]   r_cnt, w_gcnt;
  logic [1:0]        r_mode;
  logic              r_key_valid, r_op_err;
  logic [K-1:0]      r_m [N];
  logic [K-1:0]      r_rho [N];
  logic [K-1:0]      r_x [N];
  logic [K-1:0]      r_y [N];
  logic [K-1:0]      r_res [N];
  logic [K-1:0]      r_m1;
  logic [ADDR_W-1:0] w_idx;
  logic [K-1:0]      w_one;
  logic              w_mode_ok, w_start, w_last_pass, w_err, w_key_we, w_res_we;

`ifdef MM_IDDMM_CTRL_MODMUL_EN
  logic [1:0]   r_pass;
  logic [K-1:0] r_r1 [N];
  logic [K-1:0] r_r2 [N];
  assign w_mode_ok   = 1'b1;
  assign w_last_pass = (r_mode != 2'd3) || (r_pass == 2'd3);
`else
  assign w_mode_ok   = (op_mode != 2'd3);
  assign w_last_pass = 1'b1;
`endif

  // r_cnt is the beat, feed, grant or output index depending on state
  assign w_idx    = r_cnt[ADDR_W-1:0];
  assign w_one    = K'(r_cnt == '0);
  assign w_start  = (r_state == S_IDLE) && op_start && r_key_valid && w_mode_ok;
  assign w_key_we = (r_state == S_IDLE) && key_wr && !w_start;
  assign w_res_we = (r_state == S_WAIT) && core_task_grant && (r_cnt < C_N);
  assign w_gcnt   = r_cnt + (ADDR_W+1)'(core_task_grant && (r_cnt != '1));

  assign key_valid = r_key_valid;
  assign op_err    = r_op_err;
  assign busy      = (r_state != S_IDLE);
  assign out_data  = (r_state == S_OUT) ? r_res[w_idx] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_err         = 1'b0;
    in_ready      = 1'b0;
    core_wr_ena   = 3'b000;
    core_task_req = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    case (r_state)
      S_IDLE: if (op_start) begin
        if (w_start) w_next = S_LOAD;
        else         w_err  = 1'b1;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && r_cnt == C_LAST) w_next = S_FEED;
      end
      S_FEED: begin
        core_wr_ena = 3'b111;
        if (r_cnt == C_LAST) w_next = S_WAIT;
      end
      S_WAIT: begin
        core_task_req = 1'b1;
        if (core_task_end) begin
          if (w_gcnt != C_N) begin
            w_err  = 1'b1;
            w_next = S_IDLE;
          end else if (!w_last_pass) w_next = S_FEED;
          else                       w_next = S_OUT;
        end
      end
      S_OUT: begin
        out_valid = 1'b1;
        out_last  = (r_cnt == C_LAST);
        if (out_ready && r_cnt == C_LAST) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Pass operand select; the outputs read zero outside FEED
  always_comb begin
    core_wr_addr = '0;
    core_wr_x    = '0;
    core_wr_y    = '0;
    core_wr_m    = '0;
    core_wr_m1   = '0;
    if (r_state == S_FEED) begin
      core_wr_addr = w_idx;
      core_wr_m    = r_m[w_idx];
      core_wr_m1   = r_m1;
      core_wr_x    = r_x[w_idx];
      case (r_mode)
        2'd0:    core_wr_y = r_y[w_idx];
        2'd1:    core_wr_y = r_rho[w_idx];
        2'd2:    core_wr_y = w_one;
        default: begin
`ifdef MM_IDDMM_CTRL_MODMUL_EN
          case (r_pass)
            2'd0: core_wr_y = r_rho[w_idx];
            2'd1: begin core_wr_x = r_y[w_idx];  core_wr_y = r_rho[w_idx]; end
            2'd2: begin core_wr_x = r_r1[w_idx]; core_wr_y = r_r2[w_idx];  end
            default: begin core_wr_x = r_r1[w_idx]; core_wr_y = w_one; end
          endcase
`else
          core_wr_y = r_y[w_idx];
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_mode      <= '0;
      r_key_valid <= 1'b0;
      r_op_err    <= 1'b0;
`ifdef MM_IDDMM_CTRL_MODMUL_EN
      r_pass      <= '0;
`endif
    end else begin
      r_op_err <= w_err;
      if (w_start)  r_mode      <= op_mode;
      if (w_key_we) r_key_valid <= (key_sel == 2'd3);
      case (r_state)
        S_LOAD:  if (in_valid) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        S_FEED:  r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        S_WAIT:  r_cnt <= core_task_end ? '0 : w_gcnt;
        S_OUT:   if (out_ready) r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        default: r_cnt <= '0;
      endcase
`ifdef MM_IDDMM_CTRL_MODMUL_EN
      if (w_start) r_pass <= '0;
      else if (r_state == S_WAIT && core_task_end && w_next == S_FEED) r_pass <= r_pass + 2'd1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_key_we) begin
      case (key_sel)
        2'd0:    r_m[key_addr]   <= key_data;
        2'd1:    r_rho[key_addr] <= key_data;
        2'd2:    r_m1            <= key_data;
        default: ;
      endcase
    end
    if (r_state == S_LOAD && in_valid) begin
      r_x[w_idx] <= in_x;
      r_y[w_idx] <= in_y;
    end
    if (w_res_we) begin
`ifdef MM_IDDMM_CTRL_MODMUL_EN
      // MODMUL: A -> r1, B -> r2, C overwrites r1, D -> result
      if (r_mode == 2'd3 && r_pass == 2'd1)      r_r2[w_idx]  <= core_task_res;
      else if (r_mode == 2'd3 && r_pass != 2'd3) r_r1[w_idx]  <= core_task_res;
      else                                       r_res[w_idx] <= core_task_res;
`else
      r_res[w_idx] <= core_task_res;
`endif
    end
  end
endmodule

// File: tb/tb_mm_iddmm_ctrl.sv
// Scoreboard bench for mm_iddmm_ctrl: golden Montgomery core model plus arithmetic reference of each mode.
module tb_mm_iddmm_ctrl;
  localparam int K = 16, N = 4, AW = 2;

  logic clk, rst_n;
  logic key_wr, key_valid, op_start, in_valid, in_ready, out_valid, out_last, out_ready, busy, op_err;
  logic [1:0] key_sel, op_mode;
  logic [AW-1:0] key_addr, core_wr_addr;
  logic [K-1:0] key_data, in_x, in_y, out_data, core_wr_x, core_wr_y, core_wr_m, core_wr_m1, core_task_res;
  logic [2:0] core_wr_ena;
  logic core_task_req, core_task_end, core_task_grant;

  mm_iddmm_ctrl #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .key_wr(key_wr), .key_sel(key_sel), .key_addr(key_addr),
    .key_data(key_data), .key_valid(key_valid), .op_start(op_start), .op_mode(op_mode),
    .in_x(in_x), .in_y(in_y), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready), .busy(busy), .op_err(op_err),
    .core_wr_ena(core_wr_ena), .core_wr_addr(core_wr_addr), .core_wr_x(core_wr_x),
    .core_wr_y(core_wr_y), .core_wr_m(core_wr_m), .core_wr_m1(core_wr_m1),
    .core_task_req(core_task_req), .core_task_end(core_task_end),
    .core_task_grant(core_task_grant), .core_task_res(core_task_res));

  initial begin clk = 0; forever #5 clk = ~clk; end

  typedef struct { logic [K-1:0] d; logic l; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int windows = 0, err_cnt = 0, beat_idx = 0;
  int g_total = N, core_delay = 0, stall_left = 0;
  bit scripted = 0, stall_beat1 = 0, rand_bp = 0;
  logic [K-1:0] script [N];
  logic [K-1:0] cx [N], cy [N], cm [N];
  logic [63:0] cur_m;
  logic [K-1:0] cur_m1;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mulmod(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m);
    logic [127:0] p;
    if (m == 0) return 64'd0;
    p = {64'd0, a % m} * {64'd0, b % m};
    return 64'(p % {64'd0, m});
  endfunction

  function automatic logic [63:0] rmod(input logic [63:0] m);
    logic [127:0] r;
    if (m == 0) return 64'd0;
    r = 128'd1 << 64;
    return 64'(r % {64'd0, m});
  endfunction

  function automatic logic [63:0] modinv(input logic [63:0] a, input logic [63:0] m);
    longint t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = longint'(m); nr = longint'(a);
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    if (t < 0) t = t + longint'(m);
    return 64'(t);
  endfunction

  // Reference: R = 2^(K*N), results fully reduced mod m
  function automatic logic [63:0] ref_result(input logic [1:0] mode, input logic [63:0] x,
                                             input logic [63:0] y, input logic [63:0] m);
    logic [63:0] rinv;
    rinv = modinv(rmod(m), m);
    case (mode)
      2'd0:    return mulmod(mulmod(x, y, m), rinv, m);
      2'd1:    return mulmod(x, rmod(m), m);
      2'd2:    return mulmod(x, rinv, m);
      default: return mulmod(x, y, m);
    endcase
  endfunction

  // Core model: captures fed operands, answers each task_req window with grants then end
  initial begin
    int step, fi, wait_left;
    logic [63:0] vx, vy, vm, vr;
    logic [K-1:0] res_w [N];
    core_task_end = 0; core_task_grant = 0; core_task_res = '0;
    step = 0; fi = 0; wait_left = 0;
    forever begin
      @(negedge clk);
      core_task_end = 0; core_task_grant = 0;
      if (!rst_n) begin
        step = 0; fi = 0;
      end else begin
        if (core_wr_ena == 3'b111) begin
          chk(int'(core_wr_addr) == fi, "feed_addr", 64'(core_wr_addr), 64'(fi));
          chk(core_wr_m1 == cur_m1, "feed_m1", 64'(core_wr_m1), 64'(cur_m1));
          cx[core_wr_addr] = core_wr_x; cy[core_wr_addr] = core_wr_y; cm[core_wr_addr] = core_wr_m;
          fi++;
        end
        if (step == 0) begin
          if (core_task_req) begin
            windows++;
            chk(fi == N, "feed_len", 64'(fi), 64'(N));
            fi = 0;
            if (scripted) res_w = script;
            else begin
              for (int w = 0; w < N; w++) begin
                vx[w*K +: K] = cx[w]; vy[w*K +: K] = cy[w]; vm[w*K +: K] = cm[w];
              end
              vr = mulmod(mulmod(vx, vy, vm), modinv(rmod(vm), vm), vm);
              for (int w = 0; w < N; w++) res_w[w] = vr[w*K +: K];
            end
            step = 1; wait_left = core_delay;
          end
        end else if (wait_left > 0) wait_left--;
        else if (step <= g_total) begin
          core_task_grant = 1; core_task_res = res_w[(step-1) % N]; step++;
        end else begin
          core_task_end = 1; step = 0;
        end
      end
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic [K-1:0] hd;
    logic hl;
    bit held;
    exp_t e;
    held = 0;
    forever begin
      @(negedge clk);
      if (op_err) err_cnt++;
      if (!rst_n || !out_valid) held = 0;
      else begin
        if (held) chk(out_data == hd && out_last == hl, "out_hold", 64'(out_data), 64'(hd));
        if (out_ready) begin
          if (exp_q.size() == 0) chk(0, "unexpected_out", 64'(out_data), 64'd0);
          else begin
            e = exp_q.pop_front();
            chk(out_data == e.d, "out_data", 64'(out_data), 64'(e.d));
            chk(out_last == e.l, "out_last", 64'(out_last), 64'(e.l));
          end
          beat_idx = out_last ? 0 : beat_idx + 1;
          held = 0;
        end else begin
          held = 1; hd = out_data; hl = out_last;
        end
      end
    end
  end

  // Output backpressure
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      if (stall_beat1 && out_valid && beat_idx == 1 && stall_left > 0) begin
        out_ready = 0; stall_left--;
      end else if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic kw(input logic [1:0] sel, input int addr, input logic [K-1:0] d);
    key_wr = 1; key_sel = sel; key_addr = AW'(addr); key_data = d;
    @(negedge clk);
    key_wr = 0;
  endtask

  task automatic load_key(input logic [63:0] m);
    logic [63:0] rho;
    cur_m = m;
    rho = mulmod(rmod(m), rmod(m), m);
    cur_m1 = K'($urandom);
    for (int w = 0; w < N; w++) begin
      kw(2'd0, w, m[w*K +: K]);
      kw(2'd1, w, rho[w*K +: K]);
    end
    kw(2'd2, 0, cur_m1);
    chk(key_valid == 0, "key_valid_before_commit", 64'(key_valid), 64'd0);
    kw(2'd3, 0, '0);
    chk(key_valid == 1, "key_valid_commit", 64'(key_valid), 64'd1);
  endtask

  task automatic start_op(input logic [1:0] mode, input bit with_kw);
    op_start = 1; op_mode = mode;
    if (with_kw) begin key_wr = 1; key_sel = 2'd0; key_addr = '0; key_data = ~cur_m[K-1:0]; end
    @(negedge clk);
    op_start = 0; key_wr = 0;
  endtask

  task automatic feed(input logic [63:0] x, input logic [63:0] y, input bit gaps);
    int t;
    for (int b = 0; b < N; b++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin in_valid = 0; @(negedge clk); end
      in_valid = 1; in_x = x[b*K +: K]; in_y = y[b*K +: K];
      t = 0;
      while (!in_ready && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
    end
    in_valid = 0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    chk(!busy, name, 64'(busy), 64'd0);
  endtask

  task automatic expect_start_err(input logic [1:0] mode, input string name);
    start_op(mode, 0);
    chk(op_err == 1 && busy == 0, name, {62'd0, op_err, busy}, 64'd2);
    @(negedge clk);
    chk(op_err == 0, "err_pulse_len", 64'(op_err), 64'd0);
  endtask

  task automatic do_op(input logic [1:0] mode, input logic [63:0] x, input logic [63:0] y,
                       input bit gaps, input bit with_kw, input bit push);
    logic [63:0] r;
    exp_t e;
    int k;
    r = ref_result(mode, x, y, cur_m);
    if (push) for (int w = 0; w < N; w++) begin
      e.d = r[w*K +: K]; e.l = (w == N-1); exp_q.push_back(e);
    end
    start_op(mode, with_kw);
    chk(op_err == 0 && busy == 1, "start_accept", {62'd0, op_err, busy}, 64'd1);
    feed(x, y, gaps);
    if (!gaps) begin
      k = 0;
      while (!core_task_req && k < 50) begin @(negedge clk); k++; end
      chk(k == N, "req_latency", 64'(k), 64'(N));
    end
    wait_idle("op_timeout");
    chk(exp_q.size() == 0, "out_count", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] x, y, m;
    logic [1:0] mode;
    int w0, e0, t;
    rst_n = 0; key_wr = 0; key_sel = 0; key_addr = 0; key_data = 0; op_start = 0; op_mode = 0;
    in_x = 0; in_y = 0; in_valid = 0; cur_m = 64'd241; cur_m1 = '0;
    repeat (3) @(negedge clk);
    chk({key_valid, in_ready, out_valid, out_last, busy, op_err, core_wr_ena, core_task_req} == '0,
        "reset_ctrl", {54'd0, key_valid, in_ready, out_valid, out_last, busy, op_err, core_wr_ena, core_task_req}, 64'd0);
    chk(out_data == 0 && core_wr_m1 == 0, "reset_data", 64'(out_data), 64'd0);
    #2 rst_n = 1;
    @(negedge clk);

    // no key committed
    expect_start_err(2'd0, "err_no_key");
    for (int i = 0; i < 3; i++) begin
      chk(core_wr_ena == 0 && busy == 0, "no_key_idle", {60'd0, core_wr_ena, busy}, 64'd0);
      @(negedge clk);
    end

    // FROM_MONT, scripted core answers
    load_key({$urandom, $urandom} & 64'h3FFF_FFFF_FFFF_FFFF | 64'h100_0000_0001);
    scripted = 1;
    for (int w = 0; w < N; w++) script[w] = K'(w + 5);
    for (int w = 0; w < N; w++) begin
      exp_t e; e.d = K'(w + 5); e.l = (w == N-1); exp_q.push_back(e);
    end
    do_op(2'd2, 64'h0004_0003_0002_0001, 64'h0, 0, 0, 0);
    for (int w = 0; w < N; w++) chk(cy[w] == K'(w == 0), "one_operand", 64'(cy[w]), 64'(w == 0));
    scripted = 0;

    // MONT with 3-cycle stall on beat 1 and a key write coinciding with start
    stall_beat1 = 1; stall_left = 3;
    do_op(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 1, 1);
    chk(stall_left == 0, "stall_applied", 64'(stall_left), 64'd0);
    chk(key_valid == 1, "kw_with_start_ignored", 64'(key_valid), 64'd1);
    stall_beat1 = 0;

    // MODMUL on the small modulus
    load_key(64'd241);
    w0 = windows;
`ifdef MM_IDDMM_CTRL_MODMUL_EN
    do_op(2'd3, 64'd3, 64'd5, 0, 0, 1);
    chk(windows - w0 == 4, "modmul_windows", 64'(windows - w0), 64'd4);
    chk(ref_result(2'd3, 64'd3, 64'd5, 64'd241) == 64'd15, "modmul_ref", 64'd15, 64'd15);
`else
    expect_start_err(2'd3, "err_modmul_absent");
    repeat (3) @(negedge clk);
    chk(windows == w0, "modmul_no_core", 64'(windows - w0), 64'd0);
`endif

    // short grant count: error pulse, no output; start and key write while busy ignored
    g_total = 3; e0 = err_cnt;
    start_op(2'd0, 0);
    feed(64'd7, 64'd9, 0);
    op_start = 1; @(negedge clk); op_start = 0;
    chk(op_err == 0, "start_busy_no_err", 64'(op_err), 64'd0);
    kw(2'd0, 0, 16'hFFFF);
    wait_idle("short_timeout");
    @(negedge clk);
    chk(err_cnt == e0 + 1, "short_grant_err", 64'(err_cnt - e0), 64'd1);
    chk(key_valid == 1, "kw_busy_ignored", 64'(key_valid), 64'd1);
    g_total = N;
    do_op(2'd1, {$urandom, $urandom}, 64'd0, 0, 0, 1);

    // reset during WAIT
    core_delay = 30;
    start_op(2'd0, 0);
    feed(64'd11, 64'd13, 0);
    t = 0;
    while (!core_task_req && t < 50) begin @(negedge clk); t++; end
    chk(core_task_req == 1, "wait_reached", 64'(core_task_req), 64'd1);
    #2 rst_n = 0;
    #1 chk({core_task_req, busy, key_valid} == 3'b000, "reset_in_wait", {61'd0, core_task_req, busy, key_valid}, 64'd0);
    @(negedge clk); #2 rst_n = 1;
    @(negedge clk);
    core_delay = 0;
    load_key({$urandom, $urandom} & 64'h3FFF_FFFF_FFFF_FFFF | 64'h100_0000_0001);
    do_op(2'd0, {$urandom, $urandom}, {$urandom, $urandom}, 0, 0, 1);

    // randomized operations
    rand_bp = 1;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) begin
        m = {$urandom, $urandom} & 64'h3FFF_FFFF_FFFF_FFFF | 64'h100_0000_0001;
        load_key(m);
      end
      core_delay = $urandom_range(0, 3);
      mode = 2'($urandom_range(0, 3));
      x = {$urandom, $urandom}; y = {$urandom, $urandom};
`ifdef MM_IDDMM_CTRL_MODMUL_EN
      do_op(mode, x, y, 1'($urandom_range(0, 1)), 0, 1);
`else
      if (mode == 2'd3) expect_start_err(mode, "err_rand_modmul");
      else do_op(mode, x, y, 1'($urandom_range(0, 1)), 0, 1);
`endif
    end
    rand_bp = 0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
